// File: rtl/arb_client_2ph.sv
// arb_client_2ph: clocked client turning level req/rel into 2-phase r/d for one arbiter port
// Optional grant-latency counter and lat_o port are built when ARB_CLIENT_LAT_EN is defined.
module arb_client_2ph #(
   parameter int SYNC_STAGES = 2
`ifdef ARB_CLIENT_LAT_EN
   ,parameter int LAT_W = 16
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic rel_i,
   output logic gnt_o,
   output logic busy_o,
   output logic done_o,
   output logic r_o,
   output logic d_o,
   input  logic g_i,
   input  logic a_i
`ifdef ARB_CLIENT_LAT_EN
   ,output logic [LAT_W-1:0] lat_o
`endif
);
   typedef enum logic [1:0] {IDLE, REQ, GRANTED, DONE} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] gsync_q, gsync_d, async_q, async_d;
   logic r_q, r_d, d_q, d_d, gnt_q, gnt_d, done_q, done_d;
   logic g_s, a_s;
   assign g_s = gsync_q[SYNC_STAGES-1];
   assign a_s = async_q[SYNC_STAGES-1];
`ifdef ARB_CLIENT_LAT_EN
   logic [LAT_W-1:0] cnt_q, cnt_d, lat_q, lat_d, cnt_inc;
`endif
   // State and phase registers; synchronisers clear so in-reset arbiter edges are discarded
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gsync_q <= '0;
         async_q <= '0;
         r_q     <= 1'b0;
         d_q     <= 1'b0;
         gnt_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef ARB_CLIENT_LAT_EN
         cnt_q   <= '0;
         lat_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gsync_q <= gsync_d;
         async_q <= async_d;
         r_q     <= r_d;
         d_q     <= d_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
`ifdef ARB_CLIENT_LAT_EN
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
`endif
      end
   end
   // Next state: a phase is complete once its synchronised echo matches the driven phase
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = req_i ? REQ : IDLE;
         REQ:     state_d = (g_s == r_q) ? GRANTED : REQ;
         GRANTED: state_d = rel_i ? DONE : GRANTED;
         DONE:    state_d = (a_s == d_q) ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // Phase toggles, registered status and synchroniser shift
   always_comb begin
      gsync_d = {gsync_q[SYNC_STAGES-2:0], g_i};
      async_d = {async_q[SYNC_STAGES-2:0], a_i};
      r_d     = r_q ^ (state_q == IDLE && req_i);
      d_d     = d_q ^ (state_q == GRANTED && rel_i);
      gnt_d   = state_d == GRANTED;
      done_d  = state_q == DONE && state_d == IDLE;
`ifdef ARB_CLIENT_LAT_EN
      cnt_inc = &cnt_q ? cnt_q : cnt_q + LAT_W'(1);
      cnt_d   = state_q == REQ ? cnt_inc : '0;
      lat_d   = (state_q == REQ && state_d == GRANTED) ? cnt_inc : lat_q;
`endif
   end
   // Outputs come straight from flops or the state register
   always_comb begin
      busy_o = state_q != IDLE;
      gnt_o  = gnt_q;
      done_o = done_q;
      r_o    = r_q;
      d_o    = d_q;
`ifdef ARB_CLIENT_LAT_EN
      lat_o  = lat_q;
`endif
   end
endmodule

// File: tb/tb_arb_client_2ph.sv
// tb_arb_client_2ph: two clients on a behavioural 2-phase arbiter, event scoreboard
module tb_arb_client_2ph;
   localparam int S = 2;
`ifdef ARB_CLIENT_LAT_EN
   localparam int LW = 4;
   wire [LW-1:0] lat0, lat1;
`endif
   typedef struct {int cyc; int kind; bit val;} ev_t;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] req = '0, rel = '0, g = '0, a = '0;
   wire  [1:0] gnt, busy, done, r, d;
   ev_t q[2][$];
   bit   [1:0] rph = '0, dph = '0;
   logic [1:0] rp = '0, dp = '0, gp = '0;
   int n_tests = 0, n_fail = 0, edge_n = 0, gdel_v = 0, pc = 0;

   always #5 clk = ~clk;

   arb_client_2ph #(.SYNC_STAGES(S)
`ifdef ARB_CLIENT_LAT_EN
      , .LAT_W(LW)
`endif
   ) u0 (.clk(clk), .rst(rst), .req_i(req[0]), .rel_i(rel[0]), .gnt_o(gnt[0]), .busy_o(busy[0]),
         .done_o(done[0]), .r_o(r[0]), .d_o(d[0]), .g_i(g[0]), .a_i(a[0])
`ifdef ARB_CLIENT_LAT_EN
         , .lat_o(lat0)
`endif
   );
   arb_client_2ph #(.SYNC_STAGES(S)
`ifdef ARB_CLIENT_LAT_EN
      , .LAT_W(LW)
`endif
   ) u1 (.clk(clk), .rst(rst), .req_i(req[1]), .rel_i(rel[1]), .gnt_o(gnt[1]), .busy_o(busy[1]),
         .done_o(done[1]), .r_o(r[1]), .d_o(d[1]), .g_i(g[1]), .a_i(a[1])
`ifdef ARB_CLIENT_LAT_EN
         , .lat_o(lat1)
`endif
   );

   // Arbiter model: acks echo d one cycle later; grant when nobody holds, after gdel_v free cycles
   always @(posedge clk) begin
      if (rst) begin
         g <= '0; a <= '0; pc <= 0;
      end else begin
         for (int i = 0; i < 2; i++) if (d[i] != a[i]) a[i] <= d[i];
         if (g == a && r != g) begin
            if (pc >= gdel_v) begin
               pc <= 0;
               if (r[0] != g[0]) g[0] <= r[0];
               else g[1] <= r[1];
            end else pc <= pc + 1;
         end
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
      end
   endtask

   task automatic push(int i, int cyc, int kind, bit val);
      ev_t e;
      e.cyc = cyc; e.kind = kind; e.val = val;
      q[i].push_back(e);
   endtask

   task automatic pop(int i, int kind, bit val);
      ev_t e;
      if (q[i].size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL u%0d_unexpected: got event kind %0d expected none (edge %0d)", i, kind, edge_n);
      end else begin
         e = q[i].pop_front();
         chk($sformatf("u%0d_kind", i), kind, e.kind);
         chk($sformatf("u%0d_edge_k%0d", i, kind), edge_n, e.cyc);
         chk($sformatf("u%0d_val_k%0d", i, kind), val, e.val);
      end
   endtask

   // Monitor: every output change becomes an event matched against the expected queue
   always @(posedge clk) begin
      #1;
      edge_n++;
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            if (r[i] != rp[i]) pop(i, 0, r[i]);
            if (gnt[i] && !gp[i]) pop(i, 1, 1'b1);
            if (d[i] != dp[i]) pop(i, 2, d[i]);
            if (!gnt[i] && gp[i]) pop(i, 3, 1'b0);
            if (done[i]) pop(i, 4, 1'b1);
            chk($sformatf("u%0d_done_gnt", i), {31'd0, done[i] & gnt[i]}, 0);
         end
         chk("gnt_overlap", {31'd0, gnt[0] & gnt[1]}, 0);
      end
      rp = r; dp = d; gp = gnt;
   end

   function automatic logic relv(int gr, int er);
      return (edge_n == er - 1) ? 1'b1 : (edge_n >= gr && edge_n < er) ? 1'b0 : 1'($urandom_range(0, 1));
   endfunction

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         req = '0;
         rel = 2'($urandom_range(0, 3));
      end
   endtask

   // One transaction on u0; expected edges follow from arbiter delay and synchroniser depth
   task automatic txn0(int gdel, int hold, bit keep);
      int e1, gr, er, dn;
      gdel_v = gdel;
      e1 = edge_n + 1;
      gr = e1 + 1 + gdel + S + 1;
      er = gr + hold + 1;
      dn = er + 1 + S + 1;
      rph[0] ^= 1'b1; push(0, e1, 0, rph[0]);
      push(0, gr, 1, 1'b1);
      dph[0] ^= 1'b1; push(0, er, 2, dph[0]);
      push(0, er, 3, 1'b0);
      push(0, dn, 4, 1'b1);
      req[0] = 1'b1;
      while (edge_n < dn) begin
         @(negedge clk);
         req[0] = (edge_n >= dn) ? keep : 1'($urandom_range(0, 1));
         rel[0] = relv(gr, er);
         rel[1] = 1'($urandom_range(0, 1));
      end
`ifdef ARB_CLIENT_LAT_EN
      chk("lat0", {{(32-LW){1'b0}}, lat0}, (gr - e1 > (1 << LW) - 1) ? (1 << LW) - 1 : gr - e1);
`endif
   endtask

   // Simultaneous requests: u0 wins, u1 is granted once u0's acknowledge frees the arbiter
   task automatic both(int h0, int h1);
      int e1, gr0, er0, dn0, gr1, er1, dn1;
      gdel_v = 0;
      e1 = edge_n + 1;
      gr0 = e1 + 1 + S + 1; er0 = gr0 + h0 + 1; dn0 = er0 + 1 + S + 1;
      gr1 = er0 + 2 + S + 1; er1 = gr1 + h1 + 1; dn1 = er1 + 1 + S + 1;
      for (int i = 0; i < 2; i++) begin
         rph[i] ^= 1'b1; push(i, e1, 0, rph[i]);
         dph[i] ^= 1'b1;
      end
      push(0, gr0, 1, 1'b1); push(0, er0, 2, dph[0]); push(0, er0, 3, 1'b0); push(0, dn0, 4, 1'b1);
      push(1, gr1, 1, 1'b1); push(1, er1, 2, dph[1]); push(1, er1, 3, 1'b0); push(1, dn1, 4, 1'b1);
      req = 2'b11;
      while (edge_n < dn1) begin
         @(negedge clk);
         req = '0;
         rel[0] = relv(gr0, er0);
         rel[1] = relv(gr1, er1);
      end
   endtask

   initial begin
      int gr;
      req = 2'b11;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_u%0d_outs", i), {27'd0, r[i], d[i], gnt[i], busy[i], done[i]}, 0);
      end
      rst = 1'b0; req = '0;
      idle(2);
      txn0(0, 3, 1'b0);
      idle(3);
      txn0(0, 1, 1'b1);
      txn0(1, 0, 1'b1);
      txn0(0, 2, 1'b0);
      idle(2);
      for (int k = 0; k < 6; k++) begin
         bit keep;
         keep = (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
         txn0($urandom_range(0, 5), $urandom_range(0, 4), keep);
         if (!keep) idle($urandom_range(1, 3));
      end
      both(2, 1);
      idle(2);
      both(0, 3);
      idle(2);
      gdel_v = 0;
      gr = edge_n + 1 + 1 + S + 1;
      rph[0] ^= 1'b1; push(0, edge_n + 1, 0, rph[0]);
      push(0, gr, 1, 1'b1);
      req[0] = 1'b1; rel[0] = 1'b0;
      while (edge_n < gr + 1) begin
         @(negedge clk);
         req[0] = 1'($urandom_range(0, 1)); rel[0] = 1'b0;
      end
      chk("pre_rst_gnt", {31'd0, gnt[0]}, 1);
      rst = 1'b1; req[0] = 1'b1;
      @(negedge clk);
      chk("mid_rst_outs", {28'd0, r[0], d[0], gnt[0], busy[0]}, 0);
      repeat (2) @(negedge clk);
      q[0].delete(); q[1].delete();
      rph = '0; dph = '0;
      rst = 1'b0; req = '0;
      idle(2);
      txn0(0, 1, 1'b0);
      idle(2);
      txn0(20, 1, 1'b0);
      idle(1);
      txn0(3, 0, 1'b0);
      idle(S + 4);
      chk("q0_empty", q[0].size(), 0);
      chk("q1_empty", q[1].size(), 0);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("end_u%0d_r_eq_d", i), {31'd0, r[i] ^ d[i]}, 0);
         chk($sformatf("end_u%0d_busy", i), {31'd0, busy[i]}, 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
